imm_decode_stage: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage of the pipelined core. It extracts and sign-extends the immediate for every RV32I/RV64I base format (I, S, B, U, J, shift-amount). It classifies the instruction format and flags unrecognised opcodes. A two-entry skid buffer with valid/ready handshake and flush sits between fetch/IF-ID and the ID-EX register. Latency is one cycle, with full throughput under backpressure.

---
 rtl/imm_decode_stage.sv | 172 +++++++++++++++++
 tb/tb_imm_decode_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - RV32I/RV64I immediate decode stage with two-entry skid buffer
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [31:0]     imm32;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;
  entry_t          in_entry;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Immediate is built sign-extended to 32 bits; imm32[31] then fills the upper XLEN bits.
  always_comb begin
    imm32   = 32'd0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opcode)
      7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        dec_fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0010011: begin
        if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          if (XLEN == 64) imm32 = {26'd0, in_instr[25:20]};
          else            imm32 = {27'd0, in_instr[24:20]};
        end else begin
          dec_fmt = FMT_I;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011: dec_fmt = FMT_NONE;
      7'b0011011: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            dec_fmt = FMT_SHAMT;
            imm32   = {27'd0, in_instr[24:20]};
          end else begin
            dec_fmt = FMT_I;
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
          end
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0111011: dec_ill = (XLEN != 64);
      default:    dec_ill = 1'b1;
    endcase
  end

  generate
    if (XLEN == 64) begin : g_ext64
      assign dec_imm = {{32{imm32[31]}}, imm32};
    end else begin : g_ext32
      assign dec_imm = imm32;
    end
  endgenerate

  assign in_entry = '{imm: dec_imm, fmt: dec_fmt, tag: in_tag, ill: dec_ill};

  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   accept;

  assign accept = in_valid && !skid_valid_q;

  // Skid is only ever filled while main is stalled, so it is empty whenever
  // an input can be accepted; draining main therefore never races with a refill.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_d       = in_entry;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready    = !skid_valid_q;
  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_tag     = main_q.tag;
  assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed bench for imm_decode_stage at XLEN 32 and 64
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [15:0] in_tag;
  logic        out_ready;

  logic        r32_in_ready, r32_out_valid, r32_out_illegal;
  logic [31:0] r32_out_imm;
  logic [2:0]  r32_out_fmt;
  logic [15:0] r32_out_tag;
  logic        r64_in_ready, r64_out_valid, r64_out_illegal;
  logic [63:0] r64_out_imm;
  logic [2:0]  r64_out_fmt;
  logic [15:0] r64_out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r32_in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(r32_out_valid), .out_ready(out_ready), .out_imm(r32_out_imm),
    .out_fmt(r32_out_fmt), .out_tag(r32_out_tag), .out_illegal(r32_out_illegal)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(r64_in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(r64_out_valid), .out_ready(out_ready), .out_imm(r64_out_imm),
    .out_fmt(r64_out_fmt), .out_tag(r64_out_tag), .out_illegal(r64_out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt32;
    logic [31:0] imm32;
    logic        ill32;
    logic [2:0]  fmt64;
    logic [63:0] imm64;
    logic        ill64;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    in_instr = 32'h0;
    in_tag   = 16'h0;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b0, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE112E23, 3'd2, 32'hFFFFFFFC, 1'b0, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[3]  = '{32'h123450B7, 3'd4, 32'h12345000, 1'b0, 3'd4, 64'h0000000012345000, 1'b0};
    vecs[4]  = '{32'hFF9FF06F, 3'd5, 32'hFFFFFFF8, 1'b0, 3'd5, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    vecs[5]  = '{32'h4030D093, 3'd6, 32'h00000003, 1'b0, 3'd6, 64'h0000000000000003, 1'b0};
    vecs[6]  = '{32'h00000000, 3'd0, 32'h00000000, 1'b1, 3'd0, 64'h0,                1'b1};
    vecs[7]  = '{32'h0000009B, 3'd0, 32'h00000000, 1'b1, 3'd1, 64'h0,                1'b0};
    vecs[8]  = '{32'h03F09093, 3'd6, 32'h0000001F, 1'b0, 3'd6, 64'h000000000000003F, 1'b0};
    vecs[9]  = '{32'h0000003B, 3'd0, 32'h00000000, 1'b1, 3'd0, 64'h0,                1'b0};
    vecs[10] = '{32'h800000B7, 3'd4, 32'h80000000, 1'b0, 3'd4, 64'hFFFFFFFF80000000, 1'b0};
    vecs[11] = '{32'h00000033, 3'd0, 32'h00000000, 1'b0, 3'd0, 64'h0,                1'b0};
    vecs[12] = '{32'h0000009A, 3'd0, 32'h00000000, 1'b1, 3'd0, 64'h0,                1'b1};
    vecs[13] = '{32'hFFF0101B, 3'd0, 32'h00000000, 1'b1, 3'd6, 64'h000000000000001F, 1'b0};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive_idle();

    // reset with random inputs
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_instr  = $urandom;
      in_tag    = 16'($urandom);
      out_ready = 1'($urandom);
      flush     = 1'($urandom);
      #1;
      check("rst_out_valid", {63'd0, r32_out_valid}, 64'd0);
      check("rst_out_imm32", {32'd0, r32_out_imm}, 64'd0);
      check("rst_out_imm64", r64_out_imm, 64'd0);
      check("rst_in_ready", {63'd0, r32_in_ready}, 64'd1);
      check("rst_fmt_tag_ill", {44'd0, r32_out_fmt, r32_out_tag, r32_out_illegal}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive_idle();

    // back-to-back table vectors, one-cycle latency
    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("vec_valid32", {63'd0, r32_out_valid}, 64'd1);
        check("vec_tag32", {48'd0, r32_out_tag}, {48'd0, 16'h0100 + 16'(i - 1)});
        check("vec_fmt32", {61'd0, r32_out_fmt}, {61'd0, vecs[i-1].fmt32});
        check("vec_imm32", {32'd0, r32_out_imm}, {32'd0, vecs[i-1].imm32});
        check("vec_ill32", {63'd0, r32_out_illegal}, {63'd0, vecs[i-1].ill32});
        check("vec_valid64", {63'd0, r64_out_valid}, 64'd1);
        check("vec_tag64", {48'd0, r64_out_tag}, {48'd0, 16'h0100 + 16'(i - 1)});
        check("vec_fmt64", {61'd0, r64_out_fmt}, {61'd0, vecs[i-1].fmt64});
        check("vec_imm64", r64_out_imm, vecs[i-1].imm64);
        check("vec_ill64", {63'd0, r64_out_illegal}, {63'd0, vecs[i-1].ill64});
      end
      if (i < 14) begin
        in_valid = 1'b1;
        in_instr = vecs[i].instr;
        in_tag   = 16'h0100 + 16'(i);
      end else begin
        drive_idle();
      end
    end
    @(negedge clk);
    check("drain_valid", {63'd0, r32_out_valid}, 64'd0);

    // backpressure: A in main, B in skid, C held
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 16'hA;
    @(negedge clk);
    check("bp_ready_after_A", {63'd0, r32_in_ready}, 64'd1);
    in_tag = 16'hB; in_instr = 32'h123450B7;
    @(negedge clk);
    check("bp_ready_low", {63'd0, r32_in_ready}, 64'd0);
    check("bp_tag_A", {48'd0, r32_out_tag}, 64'hA);
    in_tag = 16'hC; in_instr = 32'h4030D093;
    @(negedge clk);
    check("bp_hold_tag_A", {48'd0, r32_out_tag}, 64'hA);
    check("bp_hold_imm_A", {32'd0, r32_out_imm}, 64'hFFFFFFFF);
    check("bp_hold_ready", {63'd0, r32_in_ready}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_out_B_valid", {63'd0, r32_out_valid}, 64'd1);
    check("bp_out_B_tag", {48'd0, r32_out_tag}, 64'hB);
    check("bp_out_B_imm", {32'd0, r32_out_imm}, 64'h12345000);
    @(negedge clk);
    check("bp_out_C_tag", {48'd0, r32_out_tag}, 64'hC);
    check("bp_out_C_fmt", {61'd0, r32_out_fmt}, 64'd6);
    drive_idle();
    @(negedge clk);
    check("bp_empty", {63'd0, r32_out_valid}, 64'd0);

    // flush with both entries full and an input offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 16'hF1;
    @(negedge clk);
    in_tag = 16'hF2;
    @(negedge clk);
    check("fl_skid_full", {63'd0, r32_in_ready}, 64'd0);
    in_tag = 16'hF3; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive_idle();
    out_ready = 1'b1;
    check("fl_valid", {63'd0, r32_out_valid}, 64'd0);
    check("fl_ready", {63'd0, r32_in_ready}, 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("fl_no_ghost", {63'd0, r32_out_valid | r64_out_valid}, 64'd0);
    end

    // async reset while skid is full
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFE112E23; in_tag = 16'hE1;
    @(negedge clk);
    in_tag = 16'hE2;
    @(negedge clk);
    drive_idle();
    check("ar_pre_full", {62'd0, r32_out_valid, r32_in_ready}, 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid_drop", {63'd0, r32_out_valid}, 64'd0);
    check("ar_ready_up", {63'd0, r32_in_ready}, 64'd1);
    check("ar_imm_clear", {32'd0, r32_out_imm}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hFE000EE3; in_tag = 16'hD1;
    @(negedge clk);
    drive_idle();
    check("ar_new_valid", {63'd0, r32_out_valid}, 64'd1);
    check("ar_new_tag", {48'd0, r32_out_tag}, 64'hD1);
    check("ar_new_imm64", r64_out_imm, 64'hFFFFFFFFFFFFFFFC);
    @(negedge clk);
    check("ar_no_dup", {63'd0, r32_out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
